lagarto_vfpu_xcpt_acc: RTL and testbench

Multi-lane, pipelined IEEE-754 exception-flag evaluator and sticky accumulator for the Lagarto vector FPU. Each accepted beat carries LANES post-rounding results. Each lane's exponent and mantissa are classified into the NV/DZ/OF/UF/NX flags. Flags of active lanes are OR-reduced across all beats of one vector instruction, and one 5-bit fflags word per instruction is handed to the vector CSR/commit logic through a valid/ready handshake.

---
 rtl/lagarto_vfpu_xcpt_acc.sv | 187 ++++++++++++++++++
 tb/tb_lagarto_vfpu_xcpt_acc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagarto_vfpu_xcpt_acc.sv
// lagarto_vfpu_xcpt_acc
// Multi-lane IEEE-754 exception-flag evaluator and sticky accumulator for the
// Lagarto vector FPU. Each beat carries LANES post-rounding results. They are
// classified into {NV,DZ,OF,UF,NX} per lane (stage S1), then OR-merged into a
// sticky word per vector instruction (stage S2). One fflags word per instruction
// is offered to the CSR/commit logic.
//
// Optional feature: define LAGARTO_VFPU_XCPT_LANE_FLAGS_EN to build the
// per-lane flag register behind lane_flags_o. Otherwise lane_flags_o is tied to 0.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are 1. Beat side: valid_i/ready_o, where ready_o depends only on state.
// Flags side: flags_valid_o/flags_ready_i, where flags_valid_o holds with stable
// data until it is taken. flush_i cancels any transfer in the same cycle.

module lagarto_vfpu_xcpt_acc #(
  parameter int LANES = 4,
  parameter int EXP_W = 12,
  parameter int MAN_W = 55,
  parameter int CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     last_i,
  input  logic [LANES-1:0]         mask_i,
  input  logic [LANES*EXP_W-1:0]   exponent_i,
  input  logic [LANES*MAN_W-1:0]   mantissa_i,
  input  logic [LANES-1:0]         overflow_round_i,
  input  logic [LANES-1:0]         invalid_operation_i,
  input  logic [LANES-1:0]         div_zero_i,
  output logic                     flags_valid_o,
  input  logic                     flags_ready_i,
  output logic [4:0]               fflags_o,
  output logic                     all_zero_o,
  output logic [CNT_W-1:0]         beat_count_o,
  output logic [LANES*5-1:0]       lane_flags_o,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LANES*5-1:0] beat_flags;
  logic [LANES-1:0]   lane_zero;
  logic               beat_zero;
  logic               accept;

  logic               s1_valid_q;
  logic [LANES*5-1:0] s1_flags_q;
  logic               s1_zero_q;
  logic [4:0]         s1_or;

  logic [4:0]         sticky_q;
  logic               all_zero_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               handshake;

  // Per-lane classification of the incoming beat; masked lanes are silent and count as zero.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             of_f;
    logic             nx_f;
    logic             uf_f;
    logic             zero_f;

    assign e      = exponent_i[g*EXP_W +: EXP_W];
    assign m      = mantissa_i[g*MAN_W +: MAN_W];
    // The exponent MSB flags an out-of-range result; an all-ones biased field is Inf.
    assign of_f   = ((&e[EXP_W-2:0]) | e[EXP_W-1]) & ~invalid_operation_i[g];
    // Rounding overflow only counts as inexact when it did not become a true overflow.
    assign nx_f   = (|m[1:0]) | (overflow_round_i[g] & ~of_f);
    assign uf_f   = (e == '0) & (m != '0);
    assign zero_f = (e == '0) & (m[MAN_W-1:2] == '0);

    assign beat_flags[g*5 +: 5] = mask_i[g] ?
        {invalid_operation_i[g], div_zero_i[g], of_f, uf_f, nx_f} : 5'b00000;
    assign lane_zero[g] = ~mask_i[g] | zero_f;
  end

  assign beat_zero = &lane_zero;
  assign ready_o   = (state_q == ST_IDLE) | (state_q == ST_ACCUM);
  assign accept    = valid_i & ready_o & ~flush_i;
  assign handshake = (state_q == ST_DONE) & flags_ready_i;

  // OR-reduce the registered lane flags into one beat-level flag word.
  always_comb begin
    s1_or = 5'b00000;
    for (int l = 0; l < LANES; l++) begin
      s1_or = s1_or | s1_flags_q[l*5 +: 5];
    end
  end

  // Instruction FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN means the last beat of the instruction sits in S1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          state_d = last_i ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (flags_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // Stage 1: capture the classified flags and zero status of each accepted beat.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      s1_valid_q <= 1'b0;
      s1_flags_q <= '0;
      s1_zero_q  <= 1'b1;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_flags_q <= beat_flags;
        s1_zero_q  <= beat_zero;
      end
    end
  end

  // Stage 2: sticky accumulation, cleared when the consumer takes the word.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i || handshake) begin
      sticky_q   <= 5'b00000;
      all_zero_q <= 1'b1;
      beat_cnt_q <= '0;
    end else if (s1_valid_q) begin
      sticky_q   <= sticky_q | s1_or;
      all_zero_q <= all_zero_q & s1_zero_q;
      if (beat_cnt_q != {CNT_W{1'b1}}) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

`ifdef LAGARTO_VFPU_XCPT_LANE_FLAGS_EN
  logic [LANES*5-1:0] lane_flags_q;

  // Keep a copy of the most recent beat's per-lane flags for debug/trace.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      lane_flags_q <= '0;
    end else if (s1_valid_q) begin
      lane_flags_q <= s1_flags_q;
    end
  end

  assign lane_flags_o = lane_flags_q;
`else
  assign lane_flags_o = '0;
`endif

  assign flags_valid_o = (state_q == ST_DONE);
  assign fflags_o      = sticky_q;
  assign all_zero_o    = all_zero_q;
  assign beat_count_o  = beat_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lagarto_vfpu_xcpt_acc.sv
// Directed testbench for lagarto_vfpu_xcpt_acc (LANES=4, EXP_W=12, MAN_W=55).
// Inputs change just after the falling edge, and outputs are sampled at the falling edge.

module tb_lagarto_vfpu_xcpt_acc;

  localparam int LANES = 4;
  localparam int EXP_W = 12;
  localparam int MAN_W = 55;
  localparam int CNT_W = 8;

  logic                   clk_i;
  logic                   rstn_i;
  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic                   last_i;
  logic [LANES-1:0]       mask_i;
  logic [LANES*EXP_W-1:0] exponent_i;
  logic [LANES*MAN_W-1:0] mantissa_i;
  logic [LANES-1:0]       overflow_round_i;
  logic [LANES-1:0]       invalid_operation_i;
  logic [LANES-1:0]       div_zero_i;
  logic                   flags_valid_o;
  logic                   flags_ready_i;
  logic [4:0]             fflags_o;
  logic                   all_zero_o;
  logic [CNT_W-1:0]       beat_count_o;
  logic [LANES*5-1:0]     lane_flags_o;
  logic [1:0]             dbg_state_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [4:0] exp_q[$];

  lagarto_vfpu_xcpt_acc #(
    .LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .flush_i            (flush_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .last_i             (last_i),
    .mask_i             (mask_i),
    .exponent_i         (exponent_i),
    .mantissa_i         (mantissa_i),
    .overflow_round_i   (overflow_round_i),
    .invalid_operation_i(invalid_operation_i),
    .div_zero_i         (div_zero_i),
    .flags_valid_o      (flags_valid_o),
    .flags_ready_i      (flags_ready_i),
    .fflags_o           (fflags_o),
    .all_zero_o         (all_zero_o),
    .beat_count_o       (beat_count_o),
    .lane_flags_o       (lane_flags_o),
    .dbg_state_o        (dbg_state_o)
  );

  // Clock and watchdog.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", err_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Neutral beat: all lanes active, normal magnitude, exact, no exceptions.
  task automatic clear_beat();
    mask_i              = 4'b1111;
    overflow_round_i    = '0;
    invalid_operation_i = '0;
    div_zero_i          = '0;
    for (int l = 0; l < LANES; l++) begin
      exponent_i[l*EXP_W +: EXP_W] = 12'h3FF;
      mantissa_i[l*MAN_W +: MAN_W] = '0;
    end
  endtask

  task automatic set_lane(input int l, input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    exponent_i[l*EXP_W +: EXP_W] = e;
    mantissa_i[l*MAN_W +: MAN_W] = m;
  endtask

  // Present one beat for a single edge; called at a falling edge, returns at the next one.
  task automatic push_beat(input logic lst);
    valid_i = 1'b1;
    last_i  = lst;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
    clear_beat();
  endtask

  // Called right after the last beat was accepted: checks latency and the result word.
  task automatic expect_done(input string tag, input logic [CNT_W-1:0] cnt, input logic az);
    logic [4:0] exp_ff;
    check({tag, "_ready_drop"}, ready_o, 1'b0);
    check({tag, "_not_yet_valid"}, flags_valid_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, "_flags_valid"}, flags_valid_o, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
      exp_ff = 5'b0;
    end else begin
      exp_ff = exp_q.pop_front();
    end
    check({tag, "_fflags"}, fflags_o, exp_ff);
    check({tag, "_beat_count"}, beat_count_o, cnt);
    check({tag, "_all_zero"}, all_zero_o, az);
  endtask

  task automatic take_flags(input string tag);
    flags_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flags_ready_i = 1'b0;
    check({tag, "_hs_valid_low"}, flags_valid_o, 1'b0);
    check({tag, "_hs_ready"}, ready_o, 1'b1);
    check({tag, "_hs_fflags_clr"}, fflags_o, 5'b0);
    check({tag, "_hs_count_clr"}, beat_count_o, '0);
    check({tag, "_hs_all_zero_set"}, all_zero_o, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_flags_valid"}, flags_valid_o, 1'b0);
    check({tag, "_fflags"}, fflags_o, 5'b0);
    check({tag, "_all_zero"}, all_zero_o, 1'b1);
    check({tag, "_beat_count"}, beat_count_o, '0);
    check({tag, "_lane_flags"}, lane_flags_o, '0);
    check({tag, "_state"}, dbg_state_o, 2'd0);
  endtask

  initial begin
    rstn_i        = 1'b0;
    flush_i       = 1'b0;
    valid_i       = 1'b0;
    last_i        = 1'b0;
    flags_ready_i = 1'b0;
    exponent_i    = '0;
    mantissa_i    = '0;
    clear_beat();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_values("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Single last beat, lane2 exponent saturated -> OF only.
    set_lane(2, 12'h7FF, '0);
    exp_q.push_back(5'b00100);
    push_beat(1'b1);
    expect_done("of_single", 8'd1, 1'b0);
`ifdef LAGARTO_VFPU_XCPT_LANE_FLAGS_EN
    check("of_single_lane_flags", lane_flags_o, 20'h01000);
`else
    check("of_single_lane_flags_tied", lane_flags_o, 20'h0);
`endif
    take_flags("of_single");

    // Three back-to-back beats: NX, then UF, then NV with OF suppressed.
    set_lane(0, 12'h3FF, 55'h1);
    push_beat(1'b0);
    set_lane(1, 12'h000, 55'h4);
    push_beat(1'b0);
    set_lane(3, 12'hFFF, '0);
    invalid_operation_i = 4'b1000;
    exp_q.push_back(5'b10011);
    push_beat(1'b1);
    expect_done("three_beats", 8'd3, 1'b0);
    take_flags("three_beats");

    // Divide-by-zero on all lanes, only lanes 0 and 2 active.
    div_zero_i = 4'b1111;
    mask_i     = 4'b0101;
    exp_q.push_back(5'b01000);
    push_beat(1'b1);
    expect_done("dz_masked", 8'd1, 1'b0);
    take_flags("dz_masked");

    // Fully masked beat with huge, invalid operands: accepted, counted, silent, zero.
    mask_i              = 4'b0000;
    invalid_operation_i = 4'b1111;
    for (int l = 0; l < LANES; l++) set_lane(l, 12'hFFF, 55'h3);
    exp_q.push_back(5'b00000);
    push_beat(1'b1);
    expect_done("mask_none", 8'd1, 1'b1);
    take_flags("mask_none");

    // All-zero operands on active lanes: zero, and not underflow.
    for (int l = 0; l < LANES; l++) set_lane(l, 12'h000, '0);
    exp_q.push_back(5'b00000);
    push_beat(1'b1);
    expect_done("all_zero_ops", 8'd1, 1'b1);
    take_flags("all_zero_ops");

    // Rounding overflow: NX on a normal lane, but absorbed into OF when the exponent overflows.
    overflow_round_i = 4'b0011;
    set_lane(1, 12'h800, '0);
    exp_q.push_back(5'b00101);
    push_beat(1'b1);
    expect_done("ovf_round", 8'd1, 1'b0);

    // Hold the result for five cycles without taking it.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_ready_low", ready_o, 1'b0);
      check("hold_valid", flags_valid_o, 1'b1);
      check("hold_fflags", fflags_o, 5'b00101);
      check("hold_count", beat_count_o, 8'd1);
    end
    take_flags("ovf_round");

    // A new instruction starts right after the handshake.
    set_lane(0, 12'h3FF, 55'h2);
    exp_q.push_back(5'b00001);
    push_beat(1'b1);
    expect_done("after_hs", 8'd1, 1'b0);
    take_flags("after_hs");

    // Beat count saturates at 255.
    for (int i = 0; i < 260; i++) push_beat(i == 259);
    exp_q.push_back(5'b00000);
    expect_done("saturate", 8'd255, 1'b0);
    take_flags("saturate");

    // Flush in the same cycle the last beat is presented.
    set_lane(0, 12'h3FF, 55'h2);
    push_beat(1'b0);
    set_lane(3, 12'h7FF, '0);
    valid_i = 1'b1;
    last_i  = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
    flush_i = 1'b0;
    clear_beat();
    check("flush_state", dbg_state_o, 2'd0);
    check("flush_ready", ready_o, 1'b1);
    check("flush_count", beat_count_o, '0);
    check("flush_fflags", fflags_o, 5'b0);
    check("flush_lane_flags", lane_flags_o, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("flush_no_valid", flags_valid_o, 1'b0);
    end

    // Reset in the middle of an instruction.
    set_lane(0, 12'h3FF, 55'h1);
    push_beat(1'b0);
    push_beat(1'b0);
    check("pre_reset_count", beat_count_o, 8'd1);
    check("pre_reset_fflags", fflags_o, 5'b00001);
    check("pre_reset_state", dbg_state_o, 2'd1);
    rstn_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_values("mid_reset");
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_count", beat_count_o, '0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
